fib_step_sched: RTL

- Time-shares one Fibonacci-step datapath among NUM_REQ requesters. The datapath is an 8-bit state pair (a,b) stepped as (a,b) -> (b, a+b).
- Each requester owns a stored context (a,b). A request asks for N steps on that context.
- The block arbitrates round-robin, runs the steps on the shared stepper at one step per cycle, writes the context back, and returns the resulting value.
- Sits between the stream-generator front ends and the shared stepper.

---
 rtl/fib_step_sched.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fib_step_sched.sv
// Round-robin scheduler that time-shares one Fibonacci stepper (a,b) -> (b,a+b)
// among NUM_REQ requesters, each owning a stored (a,b) context.
module fib_step_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*CNT_W-1:0]   req_steps,
    input  logic [NUM_REQ-1:0]         req_restart,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]           rsp_value,
    output logic [WIDTH-1:0]           rsp_next,
    output logic                       busy
);

    localparam int unsigned IdW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {StIdle, StRun, StResp} state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     ctx_a_q [NUM_REQ];
    logic [WIDTH-1:0]     ctx_b_q [NUM_REQ];
    logic [IdW-1:0]       last_grant_q;
    logic [IdW-1:0]       id_q;
    logic [CNT_W-1:0]     rem_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 rsp_valid_q;
    logic [IdW-1:0]       rsp_id_q;
    logic [WIDTH-1:0]     rsp_value_q;
    logic [WIDTH-1:0]     rsp_next_q;

    logic                 gnt_found;
    logic [IdW-1:0]       gnt_idx;
    logic [IdW-1:0]       cand;
    logic [CNT_W-1:0]     gnt_steps;
    logic                 accept;

    // Search starts just after the last winner and wraps, so nobody starves.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdW'((32'(last_grant_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst && (state_q == StIdle) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept    = |req_ready;
    assign gnt_steps = req_steps[32'(gnt_idx) * CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= IdW'(NUM_REQ - 1);
            id_q         <= '0;
            rem_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_value_q  <= '0;
            rsp_next_q   <= '0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                ctx_a_q[i] <= '0;
                ctx_b_q[i] <= WIDTH'(1);
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        id_q         <= gnt_idx;
                        rem_q        <= gnt_steps;
                        last_grant_q <= gnt_idx;
                        if (req_restart[gnt_idx]) begin
                            a_q <= '0;
                            b_q <= WIDTH'(1);
                        end else begin
                            a_q <= ctx_a_q[gnt_idx];
                            b_q <= ctx_b_q[gnt_idx];
                        end
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (rem_q != '0) begin
                        a_q   <= b_q;
                        b_q   <= a_q + b_q;
                        rem_q <= rem_q - 1'b1;
                    end else begin
                        ctx_a_q[id_q] <= a_q;
                        ctx_b_q[id_q] <= b_q;
                        rsp_value_q   <= a_q;
                        rsp_next_q    <= b_q;
                        rsp_id_q      <= id_q;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_value = rsp_value_q;
    assign rsp_next  = rsp_next_q;
    assign busy      = (state_q != StIdle);

endmodule
